// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory between fetch and load/store,
// routes one-cycle-latency read data back to the issuing port, and counts grants/conflicts.
module mem_port_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  if_gnt_cnt,
  output logic [CNT_W-1:0]  d_gnt_cnt,
  output logic [CNT_W-1:0]  conf_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  // Handshake: a requester raises req with its address/data stable; the access
  // happens in the cycle gnt is high; reads return rvalid/rdata exactly one cycle later.
  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} resp_state_e;

  resp_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              fetch_pri;

  // Fetch overtakes data only once it has been denied MAX_WAIT cycles in a row.
  assign fetch_pri = (wait_cnt == WAIT_W'(MAX_WAIT));
  assign if_gnt    = rst_n & if_req & (~d_req | fetch_pri);
  assign d_gnt     = rst_n & d_req & ~(if_req & fetch_pri);

  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_wdata = d_gnt ? d_wdata : '0;

  always_comb begin
    mem_addr = '0;
    if (if_gnt)     mem_addr = if_addr;
    else if (d_gnt) mem_addr = d_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      wait_cnt <= '0;
    end else if (!fetch_pri) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    if (if_gnt)             state_d = RESP_IF;
    else if (d_gnt && !d_we) state_d = RESP_D;
  end

  // A taken branch kills the fetch response in flight without touching data.
  assign if_rvalid = (state_q == RESP_IF) & ~if_flush;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rvalid  = (state_q == RESP_D);
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_gnt_cnt <= '0;
      d_gnt_cnt  <= '0;
      conf_cnt   <= '0;
    end else begin
      if (if_gnt)          if_gnt_cnt <= if_gnt_cnt + CNT_W'(1);
      if (d_gnt)           d_gnt_cnt  <= d_gnt_cnt + CNT_W'(1);
      if (if_req && d_req) conf_cnt   <= conf_cnt + CNT_W'(1);
    end
  end

endmodule
